pq_load_sequencer: RTL and testbench

Two-phase commit sequencer that drives the load enables of the P and Q 7-bit data registers. A `request` captures an 8-bit command word (bit 0 selects the target, bits 7:1 are the payload). A matching `confirm` within a bounded window commits it as a one-cycle enable pulse to exactly one register. Timeouts and confirm/data mismatches abort with an error code. It sits between the operator inputs and the register pair and is the only source of `enableP` and `enableQ`.

---
 rtl/pq_loader_pkg.sv | 26 ++
 rtl/pq_load_sequencer_timeout_counter.sv | 34 +++
 rtl/pq_load_sequencer.sv | 126 ++++++++++++
 tb/tb_pq_load_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pq_loader_pkg.sv
// Shared types and constants for the P/Q load sequencer: FSM states, abort
// codes and the position of the target-select bit in the command word.
package pq_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2,
    ABORT  = 2'd3
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE     = 2'b00;
  localparam err_code_t ERR_TIMEOUT  = 2'b01;
  localparam err_code_t ERR_MISMATCH = 2'b10;

  // Command word bit that selects the destination register (0 = P, 1 = Q).
  localparam int TARGET_BIT = 0;

  // Counter width for a window of `timeout` cycles, never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/pq_load_sequencer_timeout_counter.sv
// Saturating ARMED-window counter: counts enabled cycles from zero and flags
// the last cycle of the confirm window; it never wraps.
module timeout_counter
  import pq_loader_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CW   = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours, as hardware does.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/pq_load_sequencer.sv
// Two-phase request/confirm sequencer that issues a single one-cycle load
// strobe to either the P or Q register, or aborts with a held error code.
module pq_load_sequencer
  import pq_loader_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int DATA_W  = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              request,
  input  logic              confirm,
  input  logic [DATA_W:0]   inputData,
  output logic              enableP,
  output logic              enableQ,
  output logic [DATA_W-1:0] loadData,
  output logic              busy,
  output logic              error,
  output logic [1:0]        errorCode
);

  state_t          state;
  state_t          next_state;
  logic [DATA_W:0] cmd;
  err_code_t       error_code;

  logic idle_take;   // request accepted from IDLE
  logic rearm;       // request without confirm while ARMED
  logic cmd_match;
  logic expired;
  logic cnt_clear;
  logic cnt_enable;

  assign idle_take = (state == IDLE)  && request;
  assign rearm     = (state == ARMED) && request && !confirm;
  assign cmd_match = (inputData == cmd);

  // The counter sits at zero outside ARMED, so every arm starts a fresh window.
  assign cnt_clear  = (state != ARMED) || rearm;
  assign cnt_enable = (state == ARMED);

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; in ARMED a confirm outranks both re-arm and expiry.
  // NOTE: next_state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (request) next_state = ARMED;
      end
      ARMED: begin
        if (confirm)      next_state = cmd_match ? COMMIT : ABORT;
        else if (request) next_state = ARMED;
        else if (expired) next_state = ABORT;
      end
      COMMIT:  next_state = IDLE;
      ABORT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command and error-code registers.
  // NOTE: cmd is cleared by reset along with the FSM so a truncated commit
  // can never leave a stale payload behind for the next arm.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd        <= '0;
      error_code <= ERR_NONE;
    end else begin
      if (idle_take || rearm) begin
        cmd <= inputData;
      end
      if (idle_take) begin
        error_code <= ERR_NONE;
      end else if ((state == ARMED) && (next_state == ABORT)) begin
        error_code <= confirm ? ERR_MISMATCH : ERR_TIMEOUT;
      end
    end
  end

  // Moore output decode: every output depends only on registered values.
  always_comb begin
    enableP  = 1'b0;
    enableQ  = 1'b0;
    loadData = '0;
    busy     = 1'b0;
    error    = 1'b0;
    unique case (state)
      ARMED: begin
        busy = 1'b1;
      end
      COMMIT: begin
        busy     = 1'b1;
        enableP  = ~cmd[TARGET_BIT];
        enableQ  =  cmd[TARGET_BIT];
        loadData = cmd[DATA_W:1];
      end
      ABORT: begin
        error = 1'b1;
      end
      default: ;
    endcase
  end

  assign errorCode = error_code;

endmodule

// File: tb/tb_pq_load_sequencer.sv
// Directed bench for pq_load_sequencer: commit to P and Q, window edge,
// timeout, mismatch, re-arm/collision and reset during a commit.
module tb_pq_load_sequencer;

  logic       clock;
  logic       reset_n;
  logic       request;
  logic       confirm;
  logic [7:0] inputData;
  logic       enableP;
  logic       enableQ;
  logic [6:0] loadData;
  logic       busy;
  logic       error;
  logic [1:0] errorCode;

  int total = 0;
  int bad   = 0;

  pq_load_sequencer #(
    .TIMEOUT (16),
    .DATA_W  (7)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .request   (request),
    .confirm   (confirm),
    .inputData (inputData),
    .enableP   (enableP),
    .enableQ   (enableQ),
    .loadData  (loadData),
    .busy      (busy),
    .error     (error),
    .errorCode (errorCode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector: {enableP, enableQ, busy, error, errorCode[1:0], loadData[6:0]}
  function automatic logic [12:0] want(input logic ep, input logic eq, input logic bz,
                                       input logic er, input logic [1:0] code,
                                       input logic [6:0] ld);
    return {ep, eq, bz, er, code, ld};
  endfunction

  function automatic logic [12:0] outs();
    return {enableP, enableQ, busy, error, errorCode, loadData};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic req, input logic conf, input logic [7:0] data);
    request   = req;
    confirm   = conf;
    inputData = data;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    check("reset_outputs", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));
    reset_n = 1'b1;
    tick();
    check("idle_after_release", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));

    // Commit to P: confirm three cycles after the request edge.
    drive(1'b1, 1'b0, 8'hA4);
    tick();
    check("p_armed", outs(), want(0, 0, 1, 0, 2'b00, 7'h00));
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    drive(1'b0, 1'b1, 8'hA4);
    tick();
    check("p_commit", outs(), want(1, 0, 1, 0, 2'b00, 7'h52));
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("p_back_idle", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));

    // Commit to Q on the last window cycle (count 15).
    drive(1'b1, 1'b0, 8'h81);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) tick();
    check("q_still_armed_at_15", outs(), want(0, 0, 1, 0, 2'b00, 7'h00));
    drive(1'b0, 1'b1, 8'h81);
    tick();
    check("q_commit_last_cycle", outs(), want(0, 1, 1, 0, 2'b00, 7'h40));
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("q_back_idle", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));

    // Timeout: error pulse in the 17th cycle after the request edge.
    drive(1'b1, 1'b0, 8'h10);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) tick();
    check("timeout_not_yet", outs(), want(0, 0, 1, 0, 2'b00, 7'h00));
    tick();
    check("timeout_abort", outs(), want(0, 0, 0, 1, 2'b01, 7'h00));
    tick();
    check("timeout_code_held", outs(), want(0, 0, 0, 0, 2'b01, 7'h00));
    tick();
    check("timeout_code_held2", outs(), want(0, 0, 0, 0, 2'b01, 7'h00));

    // Mismatch: the new request also clears the held timeout code.
    drive(1'b1, 1'b0, 8'h22);
    tick();
    check("mismatch_armed_code_cleared", outs(), want(0, 0, 1, 0, 2'b00, 7'h00));
    drive(1'b0, 1'b1, 8'h23);
    tick();
    check("mismatch_abort", outs(), want(0, 0, 0, 1, 2'b10, 7'h00));
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("mismatch_code_held", outs(), want(0, 0, 0, 0, 2'b10, 7'h00));

    // Re-arm, then request+confirm together in ARMED: confirm wins.
    drive(1'b1, 1'b0, 8'h02);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b1, 1'b0, 8'h05);
    tick();
    check("rearm_armed", outs(), want(0, 0, 1, 0, 2'b00, 7'h00));
    drive(1'b1, 1'b1, 8'h05);
    tick();
    check("collision_commit_q", outs(), want(0, 1, 1, 0, 2'b00, 7'h02));
    // Request during COMMIT is dropped; lone confirm in IDLE is ignored.
    drive(1'b1, 1'b0, 8'h04);
    tick();
    check("commit_request_dropped", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));
    drive(1'b0, 1'b1, 8'h04);
    tick();
    check("idle_confirm_ignored", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));

    // Request+confirm together from IDLE: request taken, confirm ignored.
    drive(1'b1, 1'b1, 8'h33);
    tick();
    check("idle_collision_arms", outs(), want(0, 0, 1, 0, 2'b00, 7'h00));
    drive(1'b0, 1'b1, 8'h33);
    tick();
    check("idle_collision_commit", outs(), want(0, 1, 1, 0, 2'b00, 7'h19));
    drive(1'b0, 1'b0, 8'h00);
    tick();

    // Reset asserted in the middle of a COMMIT cycle.
    drive(1'b1, 1'b0, 8'hFE);
    tick();
    drive(1'b0, 1'b1, 8'hFE);
    tick();
    check("fe_commit", outs(), want(1, 0, 1, 0, 2'b00, 7'h7F));
    drive(1'b0, 1'b0, 8'h00);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_commit", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));
    tick();
    check("reset_held", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 8'hFE);
    tick();
    check("post_reset_confirm_ignored", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));
    tick();
    check("post_reset_no_enable", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));
    drive(1'b1, 1'b0, 8'hFE);
    tick();
    drive(1'b0, 1'b1, 8'hFE);
    tick();
    check("post_reset_commit", outs(), want(1, 0, 1, 0, 2'b00, 7'h7F));
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("final_idle", outs(), want(0, 0, 0, 0, 2'b00, 7'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
